// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Supervises the system PLL from the 50 MHz reference clock. The PLL is held
//   in reset for RST_CYCLES, then the block waits up to LOCK_TIMEOUT cycles for
//   lock and retries on timeout. It requires STABLE_CYCLES of uninterrupted
//   lock before releasing the core reset. The whole sequence re-runs on loss of
//   lock while running, or on a restart request.
//
// Ports
//   refclk      in   reference clock, the only clock
//   rst         in   asynchronous active-high reset
//   restart     in   synchronous re-sequence request (level or pulse)
//   pll_locked  in   PLL lock indicator, asynchronous to refclk
//   pll_rst     out  reset to the PLL, active-high
//   core_rst    out  downstream core reset, active-high
//   ready       out  PLL locked and stable, core released
//   lock_lost   out  one-cycle pulse when lock drops while running
//   retry_cnt   out  number of lock timeouts, saturating at 15
//   state       out  debug state: 0 RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [1:0] state
);

  // One shared counter wide enough for the longest interval minus one.
  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync_meta;
  logic             r_lock_s;
  logic             r_pll_rst;
  logic             r_core_rst;
  logic             r_ready;
  logic             r_lock_lost;
  logic [3:0]       r_retry;

  state_t           w_next;
  logic             w_lost;
  logic             w_timeout;
  logic             w_enter;

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_sync_meta <= pll_locked;
      r_lock_s    <= r_sync_meta;
    end
  end

  // Next-state decision. restart overrides everything, including a
  // simultaneous lock loss, so lock_lost never fires alongside it.
  // In WAIT_LOCK the lock check comes before the timeout, so a lock that
  // arrives on the timeout cycle still wins.
  always_comb begin
    w_next    = r_state;
    w_lost    = 1'b0;
    w_timeout = 1'b0;
    if (restart) begin
      w_next = ST_RESET;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (r_cnt == RST_LAST) w_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_next = ST_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_next    = ST_RESET;
            w_timeout = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!r_lock_s) begin
            w_next = ST_WAIT_LOCK;
          end else if (r_cnt == STABLE_LAST) begin
            w_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!r_lock_s) begin
            w_next = ST_RESET;
            w_lost = 1'b1;
          end
        end
        default: w_next = ST_RESET;
      endcase
    end
  end

  // A restart counts as re-entering RESET even when already there, which
  // keeps the counter pinned at 0 while restart is held.
  assign w_enter = restart || (w_next != r_state);

  // State, counter and outputs; outputs decode the next state so they
  // change on the same edge as the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RESET;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_core_rst  <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry     <= 4'd0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_enter ? '0 : r_cnt + CNT_W'(1);
      r_pll_rst   <= (w_next == ST_RESET);
      r_core_rst  <= (w_next != ST_RUN);
      r_ready     <= (w_next == ST_RUN);
      r_lock_lost <= w_lost;
      if (w_timeout && (r_retry != 4'd15)) begin
        r_retry <= r_retry + 4'd1;
      end
    end
  end

  assign pll_rst   = r_pll_rst;
  assign core_rst  = r_core_rst;
  assign ready     = r_ready;
  assign lock_lost = r_lock_lost;
  assign retry_cnt = r_retry;
  assign state     = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with RST_CYCLES=4,
//   LOCK_TIMEOUT=32, STABLE_CYCLES=8. Inputs change 1 ns after a rising
//   edge and outputs are sampled at the same point. Edge numbers in the
//   comments are counted from the last release of rst or the last state entry.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       restart;
  logic       pll_locked;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .restart   (restart),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .core_rst  (core_rst),
    .ready     (ready),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt),
    .state     (state)
  );

  initial begin
    refclk = 1'b0;
    forever #10 refclk = ~refclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_values(input string tag);
    $display("[TB] %s: checking reset values", tag);
    check({tag, ".state"},     state,     0);
    check({tag, ".pll_rst"},   pll_rst,   1);
    check({tag, ".core_rst"},  core_rst,  1);
    check({tag, ".ready"},     ready,     0);
    check({tag, ".lock_lost"}, lock_lost, 0);
    check({tag, ".retry_cnt"}, retry_cnt, 0);
  endtask

  initial begin
    rst        = 1'b0;
    restart    = 1'b0;
    pll_locked = 1'b0;

    // Reset applied before any clock edge.
    #2 rst = 1'b1;
    #3;
    check_reset_values("por");
    ticks(2);
    rst = 1'b0;

    // Clean power-up: lock rises before edge 10, ready at edge 20.
    $display("[TB] clean power-up");
    ticks(3);                                   // edge 3
    check("pu.pll_rst_e3", pll_rst, 1);
    tick();                                     // edge 4
    check("pu.pll_rst_e4", pll_rst, 0);
    check("pu.state_e4", state, 1);
    ticks(5);                                   // edge 9
    pll_locked = 1'b1;
    ticks(2);                                   // edge 11
    check("pu.state_e11", state, 1);
    tick();                                     // edge 12
    check("pu.state_e12", state, 2);
    ticks(7);                                   // edge 19
    check("pu.ready_e19", ready, 0);
    check("pu.core_rst_e19", core_rst, 1);
    tick();                                     // edge 20
    check("pu.ready_e20", ready, 1);
    check("pu.core_rst_e20", core_rst, 0);
    check("pu.state_e20", state, 3);
    check("pu.retry_cnt", retry_cnt, 0);

    // Loss of lock in RUN, dropped before edge d.
    $display("[TB] loss in RUN");
    ticks(2);
    pll_locked = 1'b0;
    tick();                                     // d
    check("loss.state_d", state, 3);
    tick();                                     // d+1
    check("loss.ready_d1", ready, 1);
    tick();                                     // d+2
    check("loss.state_d2", state, 0);
    check("loss.lock_lost_d2", lock_lost, 1);
    check("loss.pll_rst_d2", pll_rst, 1);
    check("loss.core_rst_d2", core_rst, 1);
    check("loss.ready_d2", ready, 0);
    tick();                                     // d+3
    check("loss.lock_lost_d3", lock_lost, 0);
    pll_locked = 1'b1;
    ticks(3);                                   // d+6
    check("loss.state_d6", state, 1);
    tick();                                     // d+7
    check("loss.state_d7", state, 2);
    ticks(7);                                   // d+14
    check("loss.state_d14", state, 2);
    tick();                                     // d+15
    check("loss.state_d15", state, 3);
    check("loss.ready_d15", ready, 1);
    check("loss.retry_cnt", retry_cnt, 0);

    // One-cycle restart in RUN.
    $display("[TB] restart pulse in RUN");
    restart = 1'b1;
    tick();                                     // r1
    restart = 1'b0;
    check("rs.state_r1", state, 0);
    check("rs.lock_lost_r1", lock_lost, 0);
    check("rs.pll_rst_r1", pll_rst, 1);
    check("rs.ready_r1", ready, 0);
    ticks(4);                                   // r1+4
    check("rs.state_r4", state, 1);
    ticks(8);                                   // r1+12
    check("rs.ready_r12", ready, 0);
    tick();                                     // r1+13
    check("rs.ready_r13", ready, 1);
    check("rs.lock_lost_r13", lock_lost, 0);

    // Held restart keeps the counter at 0, then a one-cycle glitch in STABLE.
    $display("[TB] held restart and STABLE glitch");
    restart = 1'b1;
    tick();                                     // s1
    check("hold.state_s1", state, 0);
    ticks(2);                                   // s3
    check("hold.state_s3", state, 0);
    restart = 1'b0;
    ticks(3);                                   // s3+3
    check("hold.state_s6", state, 0);
    tick();                                     // s3+4
    check("hold.state_s7", state, 1);
    tick();                                     // s3+5
    check("hold.state_s8", state, 2);
    ticks(2);                                   // s3+7
    pll_locked = 1'b0;
    tick();                                     // g
    pll_locked = 1'b1;
    check("gl.state_g", state, 2);
    tick();                                     // g+1
    check("gl.state_g1", state, 2);
    tick();                                     // g+2
    check("gl.state_g2", state, 1);
    check("gl.lock_lost_g2", lock_lost, 0);
    tick();                                     // g+3
    check("gl.state_g3", state, 2);
    ticks(7);                                   // g+10
    check("gl.ready_g10", ready, 0);
    check("gl.state_g10", state, 2);
    tick();                                     // g+11
    check("gl.ready_g11", ready, 1);
    check("gl.state_g11", state, 3);

    // restart coincident with lock loss seen in RUN.
    $display("[TB] restart coincident with lock loss");
    tick();
    pll_locked = 1'b0;
    tick();                                     // d
    tick();                                     // d+1
    check("co.state_d1", state, 3);
    restart = 1'b1;
    tick();                                     // d+2
    restart = 1'b0;
    check("co.state_d2", state, 0);
    check("co.lock_lost_d2", lock_lost, 0);
    check("co.pll_rst_d2", pll_rst, 1);

    // Never locks: 4 high / 32 low, retry_cnt saturates at 15.
    for (int k = 1; k <= 16; k++) begin
      $display("[TB] no-lock attempt %0d", k);
      ticks(3);
      check("nl.pll_rst_hi", pll_rst, 1);
      tick();
      check("nl.pll_rst_lo", pll_rst, 0);
      check("nl.state_wait", state, 1);
      ticks(31);
      check("nl.state_before_to", state, 1);
      check("nl.ready", ready, 0);
      tick();
      check("nl.state_after_to", state, 0);
      check("nl.retry_cnt", retry_cnt, (k > 15) ? 15 : k);
    end

    // Asynchronous reset in the middle of WAIT_LOCK.
    $display("[TB] async reset mid-WAIT_LOCK");
    ticks(4);
    check("ar.state_wait", state, 1);
    ticks(3);
    #5 rst = 1'b1;
    #1;
    check_reset_values("ar");
    tick();
    check("ar.state_held", state, 0);
    rst = 1'b0;
    ticks(3);
    check("ar.pll_rst_e3", pll_rst, 1);
    tick();
    check("ar.pll_rst_e4", pll_rst, 0);
    check("ar.state_e4", state, 1);
    check("ar.retry_cnt", retry_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
